unidade_controle: RTL and testbench

Multicycle control FSM that sequences the existing RISC-V datapath: register bank, ULA, data memory, instruction register, program counter and the immediate converters. It replaces ad-hoc per-opcode sequencing with a deterministic fetch/decode/execute/memory/writeback schedule. It decodes lw, sw, add/sub, addi, branches (beq/bne/blt/bge/bltu/bgeu), jal, jalr and auipc. It drives every enable and select in the datapath, and counts retired instructions.

---
 rtl/unidade_controle_if.sv | 40 ++++
 rtl/unidade_controle.sv | 216 +++++++++++++++++++++
 tb/tb_unidade_controle.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/unidade_controle_if.sv
// Barramento entre a unidade de controle multiciclo e o caminho de dados RISC-V.
// master = unidade de controle, slave = caminho de dados.
interface unidade_controle_if #(
  parameter int LARGURA_CONT = 32
) ();
  logic                    habilita;
  logic [31:0]             instr;
  logic                    flag_igual;
  logic                    flag_menor;
  logic                    flag_maior_igual_u;
  logic                    carrega_IR;
  logic                    carrega_PC;
  logic [1:0]              sel_pc;
  logic [2:0]              sel_imediato;
  logic [4:0]              Ra;
  logic [4:0]              Rb;
  logic [4:0]              Rw;
  logic                    soma_ou_subtrai;
  logic                    subtraindo;
  logic                    imediato;
  logic                    WeR;
  logic                    WeM;
  logic [1:0]              sel_dinR;
  logic                    erro;
  logic [LARGURA_CONT-1:0] cont_instr;

  modport master (
    input  habilita, instr, flag_igual, flag_menor, flag_maior_igual_u,
    output carrega_IR, carrega_PC, sel_pc, sel_imediato, Ra, Rb, Rw,
           soma_ou_subtrai, subtraindo, imediato, WeR, WeM, sel_dinR,
           erro, cont_instr
  );

  modport slave (
    output habilita, instr, flag_igual, flag_menor, flag_maior_igual_u,
    input  carrega_IR, carrega_PC, sel_pc, sel_imediato, Ra, Rb, Rw,
           soma_ou_subtrai, subtraindo, imediato, WeR, WeM, sel_dinR,
           erro, cont_instr
  );
endinterface

// File: rtl/unidade_controle.sv
// Unidade de controle multiciclo: busca/decodifica/executa/memoria/escrita
// para o caminho de dados RISC-V, com contador de instrucoes retiradas.
module unidade_controle #(
  parameter int LARGURA_CONT = 32
) (
  input  logic                clk,
  input  logic                rst,
  unidade_controle_if.master  bus
);

  typedef enum logic [2:0] {
    OCIOSO     = 3'd0,
    BUSCA      = 3'd1,
    DECODIFICA = 3'd2,
    EXECUTA    = 3'd3,
    MEMORIA    = 3'd4,
    ESCRITA    = 3'd5,
    PARADO     = 3'd6
  } estado_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [LARGURA_CONT-1:0] UM = {{(LARGURA_CONT-1){1'b0}}, 1'b1};

  estado_t                 estado_r;
  estado_t                 prox_s;
  estado_t                 fim_s;
  logic [LARGURA_CONT-1:0] cont_r;
  logic [6:0]              opcode_s;
  logic [2:0]              funct3_s;
  logic [6:0]              funct7_s;
  logic                    eh_lw_s;
  logic                    eh_sw_s;
  logic                    eh_reg_s;
  logic                    eh_addi_s;
  logic                    eh_desvio_s;
  logic                    eh_jal_s;
  logic                    eh_jalr_s;
  logic                    eh_auipc_s;
  logic                    legal_s;
  logic                    tomado_s;
  logic                    retira_s;

  assign opcode_s    = bus.instr[6:0];
  assign funct3_s    = bus.instr[14:12];
  assign funct7_s    = bus.instr[31:25];
  assign eh_lw_s     = (opcode_s == OP_LOAD);
  assign eh_sw_s     = (opcode_s == OP_STORE);
  assign eh_reg_s    = (opcode_s == OP_REG);
  assign eh_addi_s   = (opcode_s == OP_IMM);
  assign eh_desvio_s = (opcode_s == OP_BRANCH);
  assign eh_jal_s    = (opcode_s == OP_JAL);
  assign eh_jalr_s   = (opcode_s == OP_JALR);
  assign eh_auipc_s  = (opcode_s == OP_AUIPC);
  // habilita is only honoured at instruction boundaries
  assign fim_s       = bus.habilita ? BUSCA : OCIOSO;
  assign bus.cont_instr = cont_r;

  // Legality of the instruction currently held in the IR.
  always_comb begin
    legal_s = 1'b0;
    if (eh_lw_s || eh_sw_s) begin
      legal_s = (funct3_s == 3'b010);
    end else if (eh_reg_s) begin
      legal_s = (funct7_s == 7'b0000000) || (funct7_s == 7'b0100000);
    end else if (eh_desvio_s) begin
      legal_s = (funct3_s != 3'b010) && (funct3_s != 3'b011);
    end else begin
      legal_s = eh_addi_s || eh_jal_s || eh_jalr_s || eh_auipc_s;
    end
  end

  // Branch outcome from the ULA flags.
  always_comb begin
    case (funct3_s)
      3'b000:  tomado_s = bus.flag_igual;
      3'b001:  tomado_s = ~bus.flag_igual;
      3'b100:  tomado_s = bus.flag_menor;
      3'b101:  tomado_s = ~bus.flag_menor;
      3'b110:  tomado_s = ~bus.flag_maior_igual_u;
      3'b111:  tomado_s = bus.flag_maior_igual_u;
      default: tomado_s = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_r <= OCIOSO;
    end else begin
      estado_r <= prox_s;
    end
  end

  // Retired-instruction counter, wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cont_r <= {LARGURA_CONT{1'b0}};
    end else if (retira_s) begin
      cont_r <= cont_r + UM;
    end else begin
      cont_r <= cont_r;
    end
  end

  // Next state and datapath controls.
  always_comb begin
    prox_s               = estado_r;
    retira_s             = 1'b0;
    bus.carrega_IR       = 1'b0;
    bus.carrega_PC       = 1'b0;
    bus.sel_pc           = 2'd0;
    bus.sel_imediato     = 3'd0;
    bus.Ra               = 5'd0;
    bus.Rb               = 5'd0;
    bus.Rw               = 5'd0;
    bus.soma_ou_subtrai  = 1'b0;
    bus.subtraindo       = 1'b0;
    bus.imediato         = 1'b0;
    bus.WeR              = 1'b0;
    bus.WeM              = 1'b0;
    bus.sel_dinR         = 2'd0;
    bus.erro             = 1'b0;

    if (estado_r == DECODIFICA || estado_r == EXECUTA ||
        estado_r == MEMORIA    || estado_r == ESCRITA) begin
      bus.Ra = bus.instr[19:15];
      bus.Rb = bus.instr[24:20];
      bus.Rw = bus.instr[11:7];
    end else begin
      bus.Ra = 5'd0;
    end

    // ULA stays configured until writeback so its result is stable for lw/sw/jalr
    if (estado_r == EXECUTA || estado_r == MEMORIA || estado_r == ESCRITA) begin
      bus.soma_ou_subtrai = 1'b1;
      bus.subtraindo      = eh_reg_s & bus.instr[30];
      bus.imediato        = eh_lw_s | eh_sw_s | eh_addi_s | eh_jalr_s;
    end else begin
      bus.soma_ou_subtrai = 1'b0;
    end

    case (estado_r)
      OCIOSO: begin
        prox_s = fim_s;
      end
      BUSCA: begin
        bus.carrega_IR = 1'b1;
        prox_s         = DECODIFICA;
      end
      DECODIFICA: begin
        prox_s = legal_s ? EXECUTA : PARADO;
      end
      EXECUTA: begin
        if (eh_desvio_s) begin
          bus.carrega_PC   = 1'b1;
          bus.sel_pc       = tomado_s ? 2'd1 : 2'd0;
          bus.sel_imediato = tomado_s ? 3'd2 : 3'd0;
          retira_s         = 1'b1;
          prox_s           = fim_s;
        end else if (eh_lw_s || eh_sw_s) begin
          bus.sel_imediato = eh_sw_s ? 3'd1 : 3'd0;
          prox_s           = MEMORIA;
        end else begin
          prox_s = ESCRITA;
        end
      end
      MEMORIA: begin
        if (eh_sw_s) begin
          bus.sel_imediato = 3'd1;
          bus.WeM          = 1'b1;
          bus.carrega_PC   = 1'b1;
          retira_s         = 1'b1;
          prox_s           = fim_s;
        end else begin
          prox_s = ESCRITA;
        end
      end
      ESCRITA: begin
        bus.WeR        = (bus.instr[11:7] != 5'd0);
        bus.carrega_PC = 1'b1;
        retira_s       = 1'b1;
        prox_s         = fim_s;
        if (eh_lw_s) begin
          bus.sel_dinR = 2'd1;
        end else if (eh_jal_s) begin
          bus.sel_dinR     = 2'd2;
          bus.sel_pc       = 2'd1;
          bus.sel_imediato = 3'd3;
        end else if (eh_jalr_s) begin
          bus.sel_dinR = 2'd2;
          bus.sel_pc   = 2'd2;
        end else if (eh_auipc_s) begin
          bus.sel_dinR     = 2'd3;
          bus.sel_imediato = 3'd4;
        end else begin
          bus.sel_dinR = 2'd0;
        end
      end
      PARADO: begin
        bus.erro = 1'b1;
        prox_s   = PARADO;
      end
      default: begin
        prox_s = OCIOSO;
      end
    endcase
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: an instruction-level model predicts every output
// on every cycle; a second instance with a 2-bit counter exercises wrap-around.
module tb_unidade_controle;

  typedef struct packed {
    logic        ir;
    logic        pc;
    logic [1:0]  sel_pc;
    logic [2:0]  sel_imm;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rw;
    logic        soma;
    logic        sub;
    logic        imm;
    logic        wer;
    logic        wem;
    logic [1:0]  dinr;
    logic        erro;
    logic [31:0] cont;
  } saida_t;

  localparam int CL_LW = 0, CL_SW = 1, CL_R = 2, CL_ADDI = 3, CL_BR = 4,
                 CL_JAL = 5, CL_JALR = 6, CL_AUIPC = 7, CL_ILEG = 8;

  logic   clk;
  logic   rst;
  saida_t atual_s;
  saida_t atual2_s;
  int     total;
  int     bad;
  logic [31:0] cm;
  bit     em_busca;

  unidade_controle_if #(.LARGURA_CONT(32)) bus ();
  unidade_controle_if #(.LARGURA_CONT(2))  bus2 ();

  unidade_controle #(.LARGURA_CONT(32)) dut (.clk(clk), .rst(rst), .bus(bus.master));
  unidade_controle #(.LARGURA_CONT(2))  dut2 (.clk(clk), .rst(rst), .bus(bus2.master));

  assign bus2.habilita           = bus.habilita;
  assign bus2.instr              = bus.instr;
  assign bus2.flag_igual         = bus.flag_igual;
  assign bus2.flag_menor         = bus.flag_menor;
  assign bus2.flag_maior_igual_u = bus.flag_maior_igual_u;

  assign atual_s = {bus.carrega_IR, bus.carrega_PC, bus.sel_pc, bus.sel_imediato,
                    bus.Ra, bus.Rb, bus.Rw, bus.soma_ou_subtrai, bus.subtraindo,
                    bus.imediato, bus.WeR, bus.WeM, bus.sel_dinR, bus.erro,
                    bus.cont_instr};
  assign atual2_s = {bus2.carrega_IR, bus2.carrega_PC, bus2.sel_pc, bus2.sel_imediato,
                     bus2.Ra, bus2.Rb, bus2.Rw, bus2.soma_ou_subtrai, bus2.subtraindo,
                     bus2.imediato, bus2.WeR, bus2.WeM, bus2.sel_dinR, bus2.erro,
                     30'd0, bus2.cont_instr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int classe(input logic [31:0] ins);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = ins[14:12];
    f7 = ins[31:25];
    case (ins[6:0])
      7'b0000011: return (f3 == 3'b010) ? CL_LW : CL_ILEG;
      7'b0100011: return (f3 == 3'b010) ? CL_SW : CL_ILEG;
      7'b0110011: return (f7 == 7'd0 || f7 == 7'b0100000) ? CL_R : CL_ILEG;
      7'b0010011: return CL_ADDI;
      7'b1100011: return (f3 == 3'b010 || f3 == 3'b011) ? CL_ILEG : CL_BR;
      7'b1101111: return CL_JAL;
      7'b1100111: return CL_JALR;
      7'b0010111: return CL_AUIPC;
      default:    return CL_ILEG;
    endcase
  endfunction

  // Cycles from fetch to retire (illegal: fetch + decode).
  function automatic int nfases(input int cl);
    case (cl)
      CL_BR:   return 3;
      CL_SW:   return 4;
      CL_LW:   return 5;
      CL_ILEG: return 2;
      default: return 4;
    endcase
  endfunction

  function automatic saida_t vazio(input logic [31:0] c);
    saida_t e;
    e      = '0;
    e.cont = c;
    return e;
  endfunction

  function automatic saida_t esperado(input int fase, input logic [31:0] ins,
                                      input logic fi, input logic fm, input logic fu,
                                      input logic [31:0] c);
    saida_t e;
    int     cl;
    logic   tomado;
    e  = vazio(c);
    cl = classe(ins);
    if (cl == CL_ILEG && fase >= 2) begin
      e.erro = 1'b1;
      return e;
    end
    if (fase == 0) begin
      e.ir = 1'b1;
      return e;
    end
    e.ra = ins[19:15];
    e.rb = ins[24:20];
    e.rw = ins[11:7];
    if (fase == 1) return e;
    e.soma = 1'b1;
    e.sub  = (cl == CL_R) && ins[30];
    e.imm  = (cl == CL_LW) || (cl == CL_SW) || (cl == CL_ADDI) || (cl == CL_JALR);
    if (cl == CL_BR) begin
      case (ins[14:12])
        3'b000:  tomado = fi;
        3'b001:  tomado = !fi;
        3'b100:  tomado = fm;
        3'b101:  tomado = !fm;
        3'b110:  tomado = !fu;
        default: tomado = fu;
      endcase
      e.pc      = 1'b1;
      e.sel_pc  = tomado ? 2'd1 : 2'd0;
      e.sel_imm = tomado ? 3'd2 : 3'd0;
      return e;
    end
    if (cl == CL_SW) e.sel_imm = 3'd1;
    if (cl == CL_SW && fase == 3) begin
      e.wem = 1'b1;
      e.pc  = 1'b1;
      return e;
    end
    if (fase == nfases(cl) - 1) begin
      e.wer = (ins[11:7] != 5'd0);
      e.pc  = 1'b1;
      case (cl)
        CL_LW:    e.dinr = 2'd1;
        CL_JAL:   begin e.dinr = 2'd2; e.sel_pc = 2'd1; e.sel_imm = 3'd3; end
        CL_JALR:  begin e.dinr = 2'd2; e.sel_pc = 2'd2; end
        CL_AUIPC: begin e.dinr = 2'd3; e.sel_imm = 3'd4; end
        default:  e.dinr = 2'd0;
      endcase
    end
    return e;
  endfunction

  task automatic compara(input string nome, input saida_t a, input saida_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nome, a, e);
    end
  endtask

  task automatic confere(input string nome, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nome, a, e);
    end
  endtask

  // One clock cycle: inputs are already driven; check both DUTs at negedge.
  task automatic ciclo(input saida_t e, input string t);
    saida_t e2;
    @(negedge clk);
    compara(t, atual_s, e);
    e2      = e;
    e2.cont = e.cont & 32'd3;
    compara({t, " w2"}, atual2_s, e2);
    @(posedge clk);
    #1;
  endtask

  task automatic partida();
    if (!em_busca) begin
      bus.habilita = 1'b1;
      ciclo(vazio(cm), "partida");
    end
  endtask

  task automatic executa(input logic [31:0] ins, input logic fi, input logic fm,
                         input logic fu, input logic hab_fim);
    int n;
    bus.instr              = ins;
    bus.flag_igual         = fi;
    bus.flag_menor         = fm;
    bus.flag_maior_igual_u = fu;
    partida();
    n = nfases(classe(ins));
    for (int f = 0; f < n; f++) begin
      bus.habilita = (f == n - 1) ? hab_fim : 1'($urandom_range(0, 1));
      ciclo(esperado(f, ins, fi, fm, fu, cm), $sformatf("%08h f%0d", ins, f));
    end
    cm       = cm + 32'd1;
    em_busca = hab_fim;
  endtask

  task automatic reinicia();
    rst          = 1'b1;
    cm           = 32'd0;
    em_busca     = 1'b0;
    bus.habilita = 1'b0;
    ciclo(vazio(cm), "reset");
    ciclo(vazio(cm), "reset");
    rst = 1'b0;
  endtask

  task automatic ilegal(input logic [31:0] ins);
    bus.instr = ins;
    partida();
    for (int f = 0; f < 5; f++) begin
      bus.habilita = 1'b1;
      ciclo(esperado(f, ins, 1'b0, 1'b0, 1'b0, cm), $sformatf("ileg %08h f%0d", ins, f));
    end
    confere("erro_sticky", {31'd0, bus.erro}, 32'd1);
    confere("cont_ileg", bus.cont_instr, 32'd1);
  endtask

  logic [31:0] desvios [8] = '{32'h00208463, 32'h00208463, 32'h0020E463, 32'h0020E463,
                               32'h00209463, 32'h0020C463, 32'h0020D463, 32'h0020F463};
  logic [2:0]  flags_d [8] = '{3'b100, 3'b000, 3'b000, 3'b001,
                               3'b000, 3'b010, 3'b010, 3'b001};
  logic [31:0] ilegais [5] = '{32'hFFFFFFFF, 32'h022081B3, 32'h0020A463,
                               32'h00800283, 32'h00501823};

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    cm    = 32'd0;
    em_busca               = 1'b0;
    bus.habilita           = 1'b0;
    bus.instr              = 32'd0;
    bus.flag_igual         = 1'b0;
    bus.flag_menor         = 1'b0;
    bus.flag_maior_igual_u = 1'b0;
    @(posedge clk);
    #1;
    reinicia();
    confere("cont_reset", bus.cont_instr, 32'd0);
    bus.habilita = 1'b0;
    ciclo(vazio(cm), "ocioso");

    executa(32'h002081B3, 1'b0, 1'b0, 1'b0, 1'b1);   // add x3,x1,x2
    executa(32'h402081B3, 1'b0, 1'b0, 1'b0, 1'b0);   // sub x3,x1,x2
    confere("cont_add_sub", bus.cont_instr, 32'd2);
    bus.habilita = 1'b0;
    ciclo(vazio(cm), "ocioso");
    executa(32'h00802283, 1'b0, 1'b0, 1'b0, 1'b1);   // lw x5,8(x0)
    executa(32'h00502823, 1'b0, 1'b0, 1'b0, 1'b0);   // sw x5,16(x0)
    confere("cont_4", bus.cont_instr, 32'd4);
    confere("cont2_wrap", {30'd0, bus2.cont_instr}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      executa(desvios[i], flags_d[i][2], flags_d[i][1], flags_d[i][0], 1'(i % 2));
    end
    executa(32'h0100006F, 1'b0, 1'b0, 1'b0, 1'b1);   // jal x0,16
    executa(32'h000100E7, 1'b0, 1'b0, 1'b0, 1'b1);   // jalr x1,0(x2)
    executa(32'h12345397, 1'b0, 1'b0, 1'b0, 1'b0);   // auipc x7
    executa(32'h00500213, 1'b0, 1'b0, 1'b0, 1'b1);   // addi x4,x0,5
    executa(32'h00000013, 1'b0, 1'b0, 1'b0, 1'b0);   // addi x0 (no write)
    confere("cont_17", bus.cont_instr, 32'd17);

    // lw interrupted by reset in its memory cycle
    bus.instr = 32'h00802283;
    partida();
    for (int f = 0; f < 3; f++) begin
      bus.habilita = 1'b1;
      ciclo(esperado(f, bus.instr, 1'b0, 1'b0, 1'b0, cm), $sformatf("lw_abort f%0d", f));
    end
    reinicia();
    confere("cont_apos_abort", bus.cont_instr, 32'd0);

    for (int i = 0; i < 5; i++) begin
      executa(32'h00500213, 1'b0, 1'b0, 1'b0, 1'b0);
      ilegal(ilegais[i]);
      reinicia();
    end
    bus.habilita = 1'b0;
    ciclo(vazio(cm), "ocioso_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
